// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state encoding
// and the decimal weight table used by the compare-and-subtract datapath.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 10^n at 64 bits; callers truncate to their datapath width and flag
    // weights that do not fit, so a narrow WIDTH never sees a wrapped weight.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] w;
        w = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            w = w * 64'd10;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_convert_ctrl_cond_sub.sv
// Conditional subtractor: unsigned difference plus a "fits" flag. The caller
// only commits diff when ge is set, so diff never needs to be valid otherwise.
module cond_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);

    // Single shared subtract and compare
    always_comb begin
        diff = a - b;
        ge   = (a >= b);
    end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter. Peels off decimal weights 10^(DIGITS-1)
// down to 10 by repeated subtraction through one shared cond_sub; whatever is
// left after the tens pass is the units digit.
//
// state  | meaning
// IDLE   | waiting for start; bin_in captured on the accepting edge
// SUB    | one compare/subtract of rem against 10^k per cycle
// DONE   | bcd_out freshly loaded, done pulses for one cycle
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int KW = $clog2(DIGITS);

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    rem;
    logic [KW-1:0]       k;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_inc;
    logic [4*DIGITS-1:0] acc_fin;
    logic [63:0]         w_full;
    logic [WIDTH-1:0]    w_sel;
    logic [WIDTH-1:0]    diff;
    logic                ge_raw;
    logic                too_big;
    logic                take;
    logic                last_digit;

    // Weight mux: select 10^k; a weight wider than rem can never be subtracted
    always_comb begin
        w_full = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (k == KW'(i)) begin
                w_full = pow10(i);
            end
        end
        too_big = |(w_full >> WIDTH);
        w_sel   = w_full[WIDTH-1:0];
    end

    cond_sub #(
        .WIDTH (WIDTH)
    ) u_cond_sub (
        .a    (rem),
        .b    (w_sel),
        .diff (diff),
        .ge   (ge_raw)
    );

    // Digit accumulator update candidates
    always_comb begin
        take       = ge_raw & ~too_big;
        last_digit = (k == KW'(1));
        acc_inc    = acc;
        for (int i = 1; i < DIGITS; i++) begin
            if (k == KW'(i)) begin
                acc_inc[4*i +: 4] = acc[4*i +: 4] + 4'd1;
            end
        end
        acc_fin = {acc[4*DIGITS-1:4], rem[3:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SUB;
            S_SUB:   if (!take && last_digit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath registers; bcd_out loads on the edge entering DONE so it is
    // valid in the same cycle as the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            k       <= '0;
            acc     <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem <= bin_in;
                        acc <= '0;
                        k   <= KW'(DIGITS - 1);
                    end
                end
                S_SUB: begin
                    if (take) begin
                        rem <= diff;
                        acc <= acc_inc;
                    end else if (!last_digit) begin
                        k <= k - KW'(1);
                    end else begin
                        acc     <= acc_fin;
                        bcd_out <= acc_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Bench for bcd_convert_ctrl (WIDTH=8, DIGITS=3). Expected result and done
// cycle are queued when a start is accepted and checked when done appears.
module tb_bcd_convert_ctrl;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin_in = '0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    bcd_convert_ctrl #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int lat(input int v);
        return 1 + ((v / 100) + 1) + (((v / 10) % 10) + 1);
    endfunction

    // Done monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Issue one start from IDLE, queue its expectation, return accept cycle
    task automatic issue(input int v, output int e_cyc);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'(v);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'hxx;
        e_cyc  = cyc;
        e.bcd  = to_bcd(v);
        e.cyc  = cyc + lat(v) - 1;
        sb.push_back(e);
    endtask

    task automatic conv(input int v);
        int ec;
        issue(v, ec);
        chk("busy_first", 32'(busy), 32'd1);
        wait_drain("conv");
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        int   ec;
        int   busy_cnt;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(0);

        // 255: busy must be high for exactly cycles 1..10
        issue(255, ec);
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("busy_cycles_255", 32'(busy_cnt), 32'd10);
        wait_drain("c255");

        // 199 with an ignored start at cycle 5
        issue(199, ec);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd42;
        @(negedge clk);
        start  = 1'b0;
        wait_drain("c199");
        repeat (6) @(negedge clk);
        chk("hold_199", 32'(bcd_out), 32'h199);
        chk("idle_after_ignore", 32'(busy), 32'd0);

        conv(9);
        conv(10);
        conv(100);

        // Back-to-back with start held high
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd37;
        @(negedge clk);
        bin_in = 8'd128;
        e.bcd  = to_bcd(37);
        e.cyc  = cyc + lat(37) - 1;
        sb.push_back(e);
        e.bcd  = to_bcd(128);
        e.cyc  = e.cyc + 2 + lat(128) - 1;
        sb.push_back(e);
        wait_drain("b2b");
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            conv(int'($urandom_range(0, 255)));
        end

        // Reset mid-conversion of 255
        issue(255, ec);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_bcd", 32'(bcd_out), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        conv(73);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_convert_ctrl.md
# bcd_convert_ctrl

Sequential binary-to-BCD converter controller. Takes a WIDTH-bit unsigned binary value and produces DIGITS packed BCD digits using a single shared compare-and-subtract datapath. It works by repeated subtraction of decimal weights, 10^(DIGITS-1) down to 10. The block sits between score/counter logic and the seven-segment display path, and replaces per-digit combinational conversion for values wider than 4 bits.

## Interface
Parameters:
- WIDTH, 8, width of the binary input; must satisfy 2^WIDTH-1 <= 10^DIGITS-1.
- DIGITS, 3, number of BCD output digits; must be >= 2.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  conversion request; sampled only in IDLE.
- bin_in  in  WIDTH  binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress (SUB and DONE states).
- done  out  1  one-cycle pulse; bcd_out is valid and updated in this cycle.
- bcd_out  out  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k]; held until the next done.

## Operation
- States: IDLE, SUB, DONE. Internal registers:
  - rem (WIDTH bits), remaining value.
  - k (digit index, clog2(DIGITS) bits).
  - acc (4*DIGITS bits), digit accumulator.
- IDLE: busy=0. When start=1 on an edge:
  - rem<=bin_in, acc<=0, k<=DIGITS-1; go to SUB.
- SUB: one compare per cycle, rem >= W(k), where W(k)=10^k.
  - True: rem<=rem-W(k) and acc digit k += 1. Stay in SUB.
  - False with k>1: k<=k-1. Stay in SUB.
  - False with k==1: acc digit 0 <= rem[3:0]; go to DONE.
- DONE: bcd_out<=acc (the registered value appears on this cycle), done=1; go to IDLE.
- start while busy=1, including during DONE, is ignored and not queued.
- bin_in is don't-care except on the accept edge.
- Arithmetic: every digit stays in 0..9 by construction. The subtractor is WIDTH bits, unsigned. rem never underflows because subtraction only occurs when ge=1.

## Timing
- Reset values: busy=0, done=0, bcd_out=0, state=IDLE, rem=0, acc=0, k=0.
- Latency: start is accepted at edge 0. done is high in cycle L = 1 + sum over k=DIGITS-1..1 of (d_k+1), where d_k is decimal digit k of the input.
- Reference latencies for WIDTH=8, DIGITS=3:
  - bin_in=0 gives L=3.
  - bin_in=255 gives L=10.
  - bin_in=199 gives the worst case, L=13.
- done is high for exactly one cycle. busy falls in the cycle after done. A new start is accepted at the earliest on the edge ending the first IDLE cycle.
- Reset mid-conversion: all outputs return to reset values immediately (asynchronously). No done pulse is produced, and the partial result is discarded.
- Back-to-back requests: start held high continuously starts a new conversion each time IDLE is reached.

## Structure
- Shared header/package bcd_pkg holds:
  - State encoding constants S_IDLE, S_SUB, S_DONE.
  - Weight function/constant table W(k)=10^k, sized to WIDTH.
- One sub-module, cond_sub:
  - Inputs: WIDTH-bit a and b.
  - Outputs: diff=a-b and ge=(a>=b).
  - The same datapath the codebase already uses for subtract-by-ten, widened to WIDTH bits.
  - Instantiated once; its b input is muxed from W(k).
- The controller FSM, registers and weight mux live in bcd_convert_ctrl.

## Test plan
- Reset: assert rst_n=0 mid-conversion of 255 -> busy=0, done=0, bcd_out=12'h000 immediately; no done pulse after rst_n=1.
- Boundary 0: start with bin_in=0 -> done in cycle 3, bcd_out=12'h000.
- Max value: start with bin_in=255 -> done in cycle 10, bcd_out=12'h255; busy high cycles 1-10.
- Worst case: start with bin_in=199 -> done in cycle 13, bcd_out=12'h199. A start pulse at cycle 5 with bin_in=42 is ignored, and bcd_out stays 12'h199 afterwards.
- Digit carry: 9 -> 12'h009 (L=3); 10 -> 12'h010 (L=4); 100 -> 12'h100 (L=4).
- Back-to-back: start held high with bin_in switching 37 then 128 -> two done pulses, bcd_out=12'h037 then 12'h128, with one IDLE cycle between them.
